// File: rtl/mips_pkg.sv
// Shared definitions for the 16-bit, 8-register, 5-stage pipeline.
package mips_pkg;

    localparam int unsigned RA_W      = 3;
    localparam int unsigned INST_W    = 16;
    localparam int unsigned OPCODE_W  = 4;

    localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

    // Opcode field values decoded by the main controller
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_LW    = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_SW    = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_JMP   = 4'h6;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// ID-stage hazard inputs, debug controls and pipeline-register controls of the sequencer.
interface pipeline_sequencer_if #(
    parameter int unsigned RA_W  = 3,
    parameter int unsigned CNT_W = 16
);
    logic            id_valid;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic            id_wen;
    logic [RA_W-1:0] id_rd;
    logic            id_branch_taken;
    logic            step_mode;
    logic            step_req;

    logic             pipe_en;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [1:0]       state;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_wen, id_rd, id_branch_taken, step_mode, step_req,
        input  pipe_en, pc_en, ifid_en, ifid_flush, idex_bubble,
               stall_cnt, flush_cnt, state
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_wen, id_rd, id_branch_taken, step_mode, step_req,
        output pipe_en, pc_en, ifid_en, ifid_flush, idex_bubble,
               stall_cnt, flush_cnt, state
    );
endinterface

// File: rtl/pipe_scoreboard.sv
// In-flight destination tracker: entry 0 is EX, entry SB_DEPTH-1 is WB.
module pipe_scoreboard #(
    parameter int unsigned RA_W     = 3,
    parameter int unsigned SB_DEPTH = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            adv,
    input  logic            in_v,
    input  logic [RA_W-1:0] in_rd,
    input  logic [RA_W-1:0] rs1,
    input  logic [RA_W-1:0] rs2,
    output logic            hit1,
    output logic            hit2
);

    logic [SB_DEPTH-1:0] v_q;
    logic [RA_W-1:0]     rd_q [SB_DEPTH];

    // Shift toward WB only when the pipeline advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < int'(SB_DEPTH); i++) begin
                rd_q[i] <= '0;
            end
        end else if (adv) begin
            v_q[0]  <= in_v;
            rd_q[0] <= in_rd;
            for (int i = 1; i < int'(SB_DEPTH); i++) begin
                v_q[i]  <= v_q[i-1];
                rd_q[i] <= rd_q[i-1];
            end
        end
    end

    // WB is included: the register file write lands too late for a same-cycle ID read
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < int'(SB_DEPTH); i++) begin
            if (v_q[i] && (rd_q[i] == rs1)) hit1 = 1'b1;
            if (v_q[i] && (rd_q[i] == rs2)) hit2 = 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: RAW stall, branch squash, run/halt/single-step control and event counters.
module pipeline_sequencer #(
    parameter int unsigned RA_W     = 3,
    parameter int unsigned SB_DEPTH = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_sequencer_if.slave  bus
);
    import mips_pkg::*;

    seq_state_t       state_q, state_d;
    logic             step_req_q;
    logic             step_edge;
    logic             pipe_en;
    logic             hit1, hit2;
    logic             stall, issue, flush;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    pipe_scoreboard #(
        .RA_W     (RA_W),
        .SB_DEPTH (SB_DEPTH)
    ) u_scoreboard (
        .clk   (clk),
        .rst   (rst),
        .adv   (pipe_en),
        .in_v  (bus.id_wen & issue),
        .in_rd (bus.id_rd),
        .rs1   (bus.id_rs1),
        .rs2   (bus.id_rs2),
        .hit1  (hit1),
        .hit2  (hit2)
    );

    // A branch waiting on an operand stalls first; it only squashes once it issues
    assign stall = bus.id_valid & ((bus.id_use_rs1 & hit1) | (bus.id_use_rs2 & hit2));
    assign issue = bus.id_valid & ~stall;
    assign flush = issue & bus.id_branch_taken;

    assign step_edge = bus.step_req & ~step_req_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            step_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_req_q <= bus.step_req;
        end
    end

    always_comb begin
        state_d = state_q;
        pipe_en = 1'b0;
        case (state_q)
            RUN: begin
                pipe_en = 1'b1;
                if (bus.step_mode) state_d = HALT;
            end
            HALT: begin
                if (!bus.step_mode)  state_d = RUN;
                else if (step_edge)  state_d = STEP;
            end
            STEP: begin
                pipe_en = 1'b1;
                state_d = bus.step_mode ? HALT : RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Saturating event counters, frozen while the pipeline is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (pipe_en) begin
            if (stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    // PC keeps loading during a flush so the branch target is fetched
    assign bus.pipe_en     = pipe_en;
    assign bus.pc_en       = pipe_en & ~stall;
    assign bus.ifid_en     = pipe_en & ~stall;
    assign bus.ifid_flush  = pipe_en & flush;
    assign bus.idex_bubble = pipe_en & stall;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer with a reference model and an expected-result queue.
module tb_pipeline_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_sequencer_if #(.RA_W(3), .CNT_W(16)) bus ();

    pipeline_sequencer #(.RA_W(3), .SB_DEPTH(3), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [6:0]  ctl;   // {state[1:0], pipe_en, pc_en, ifid_en, ifid_flush, idex_bubble}
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // reference model state
    int busy [8];
    int m_state;
    bit m_req_q;
    int m_sc, m_fc;
    int pe_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) busy[i] = 0;
        m_state = 0;
        m_req_q = 1'b0;
        m_sc    = 0;
        m_fc    = 0;
    endtask

    // One pipeline cycle: drive at posedge+1, compare at negedge, advance model at posedge
    task automatic drive(input int v, input int rs1, input int u1, input int rs2, input int u2,
                         input int wen, input int rd, input int br, input int sm, input int sr);
        exp_t e, o;
        bit   pe, st, iss, fl, edge_c;
        bus.id_valid        = v[0];
        bus.id_rs1          = 3'(rs1);
        bus.id_use_rs1      = u1[0];
        bus.id_rs2          = 3'(rs2);
        bus.id_use_rs2      = u2[0];
        bus.id_wen          = wen[0];
        bus.id_rd           = 3'(rd);
        bus.id_branch_taken = br[0];
        bus.step_mode       = sm[0];
        bus.step_req        = sr[0];

        pe  = (m_state != 1);
        st  = v[0] && ((u1[0] && busy[rs1] != 0) || (u2[0] && busy[rs2] != 0));
        iss = v[0] && !st;
        fl  = iss && br[0];
        e.ctl = {2'(m_state), pe, pe && !st, pe && !st, pe && fl, pe && st};
        e.sc  = 16'(m_sc);
        e.fc  = 16'(m_fc);
        exp_q.push_back(e);

        @(negedge clk);
        o = exp_q.pop_front();
        check("ctl", {25'd0, bus.state, bus.pipe_en, bus.pc_en, bus.ifid_en,
                      bus.ifid_flush, bus.idex_bubble}, {25'd0, o.ctl});
        check("stall_cnt", {16'd0, bus.stall_cnt}, {16'd0, o.sc});
        check("flush_cnt", {16'd0, bus.flush_cnt}, {16'd0, o.fc});
        if (bus.pipe_en) pe_seen++;

        @(posedge clk);
        if (pe) begin
            for (int i = 0; i < 8; i++) if (busy[i] > 0) busy[i]--;
            if (wen[0] && iss) busy[rd] = 3;
            if (st && m_sc < 65535) m_sc++;
            if (fl && m_fc < 65535) m_fc++;
        end
        edge_c = sr[0] && !m_req_q;
        m_req_q = sr[0];
        case (m_state)
            0: if (sm[0]) m_state = 1;
            1: if (!sm[0]) m_state = 0; else if (edge_c) m_state = 2;
            default: m_state = sm[0] ? 1 : 0;
        endcase
        #1;
    endtask

    task automatic idle(input int sm);
        drive(0, 0, 0, 0, 0, 0, 0, 0, sm, 0);
    endtask

    int sc0, fc0;

    initial begin
        rst = 1'b1;
        bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0;
        bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0; bus.id_wen = 1'b0;
        bus.id_rd = '0; bus.id_branch_taken = 1'b0;
        bus.step_mode = 1'b0; bus.step_req = 1'b0;
        model_reset();

        #12;
        check("rst_state",     32'(bus.state), 32'd0);
        check("rst_pipe_en",   32'(bus.pipe_en), 32'd1);
        check("rst_pc_en",     32'(bus.pc_en), 32'd1);
        check("rst_ifid_en",   32'(bus.ifid_en), 32'd1);
        check("rst_flush",     32'(bus.ifid_flush), 32'd0);
        check("rst_bubble",    32'(bus.idex_bubble), 32'd0);
        check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // back-to-back RAW on rs1: 3 stalls, issue on the 4th
        drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        repeat (4) drive(1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        check("raw_stall_cnt", 32'(bus.stall_cnt), 32'd3);

        // two independent instructions between producer and rs2 reader: 1 stall
        drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        drive(1, 1, 1, 7, 1, 1, 6, 0, 0, 0);
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        check("gap2_stall_cnt", 32'(bus.stall_cnt), 32'd4);
        idle(0); idle(0); idle(0);

        // taken branch without hazard squashes one slot; not-taken does not
        drive(1, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        idle(0);
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        check("br_flush_cnt", 32'(bus.flush_cnt), 32'd1);

        // branch dependent on the preceding write: 3 stalls then 1 flush
        sc0 = m_sc; fc0 = m_fc;
        drive(1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        repeat (4) drive(1, 4, 1, 0, 0, 0, 0, 1, 0, 0);
        idle(0);
        check("dep_br_stalls", 32'(bus.stall_cnt) - 32'(sc0), 32'd3);
        check("dep_br_flushes", 32'(bus.flush_cnt) - 32'(fc0), 32'd1);

        // single-step: producer issues in the last RUN cycle, consumer advances one step per edge
        drive(1, 0, 0, 0, 0, 1, 3, 0, 1, 0);
        pe_seen = 0;
        for (int k = 0; k < 3; k++) begin
            drive(1, 3, 1, 0, 0, 0, 0, 0, 1, 0);
            drive(1, 3, 1, 0, 0, 0, 0, 0, 1, 1);
            drive(1, 3, 1, 0, 0, 0, 0, 0, 1, 0);
        end
        drive(1, 3, 1, 0, 0, 0, 0, 0, 1, 0);
        check("step_pipe_en_cycles", 32'(pe_seen), 32'd3);
        // leaving HALT with a simultaneous step edge: RUN takes priority
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 1);
        check("halt_exit_state", 32'(bus.state), 32'd0);
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);

        // async reset while halted with a stall pending
        drive(1, 0, 0, 0, 0, 1, 6, 0, 1, 0);
        drive(1, 0, 0, 6, 1, 0, 0, 0, 1, 0);
        bus.step_mode = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_state",     32'(bus.state), 32'd0);
        check("midrst_pipe_en",   32'(bus.pipe_en), 32'd1);
        check("midrst_bubble",    32'(bus.idex_bubble), 32'd0);
        check("midrst_pc_en",     32'(bus.pc_en), 32'd1);
        check("midrst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        check("midrst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1, 0, 0, 6, 1, 0, 0, 0, 0, 0);

        // randomized traffic, including mode changes and step requests
        for (int k = 0; k < 300; k++) begin
            drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 1 : 0, int'($urandom_range(0, 1)));
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
